bmp_rgb565_pack: RTL
====================

Name: bmp_rgb565_pack

Overview:
- Sits between the SD card read controller and the SDRAM write FIFO port in the SD-to-HDMI picture path.
- Consumes the 16-bit read words of a 24-bit BMP file in file order and strips the file header and the per-row padding.
- Assembles B,G,R byte triplets and emits one RGB565 word per pixel, with a write strobe for the SDRAM controller.
- Flags frame completion so that surplus sector bytes are discarded.

Parameters:
- H_PIX, 1024, image width in pixels.
- V_PIX, 768, image height in pixels.
- HDR_BYTES, 54, BMP header bytes to skip; must be even.

Ports:
- clk  in  1  50 MHz SD-side clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse; begins a new picture.
- rd_val_en  in  1  input word valid, from the SD read controller.
- rd_val_data  in  16  input word; [15:8] is the earlier file byte, [7:0] the later.
- pix_en  out  1  one-cycle strobe: pix_data holds a valid pixel.
- pix_data  out  16  RGB565 pixel, {R[7:3],G[7:2],B[7:3]}.
- busy  out  1  high from start until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Outputs: pix_en=0, pix_data=0, busy=0, frame_done=0.
  - Internal state: state=IDLE, all counters 0, byte phase 0, partial B/G registers 0.
  - Reset mid-frame aborts the frame; no frame_done is issued.
- Derived constants:
  - ROW_BYTES = H_PIX*3.
  - ROW_PAD = (4 - ROW_BYTES%4)%4, giving 0 for 1024 and 3 for H_PIX=3.
  - PIX_NUM = H_PIX*V_PIX.
  - The pixel counter is 24 bits.
- State IDLE:
  - rd_val_en is ignored.
  - start -> HEADER; clears the header, row-byte and pixel counters and the byte phase; busy=1 on the next cycle.
- State HEADER:
  - Each valid word consumes 2 bytes.
  - After HDR_BYTES/2 words -> PIXEL. The word that completes the header carries no pixel bytes.
- State PIXEL: each valid word presents two bytes, processed in order (high byte, then low byte), within one cycle.
  - Per byte, when the row-byte count is below ROW_BYTES:
    - phase 0 stores B.
    - phase 1 stores G.
    - phase 2 forms the pixel from the stored B and G plus this byte as R, and phase returns to 0.
  - Per byte, when the row-byte count is at or above ROW_BYTES: the byte is a pad byte and is dropped. After ROW_BYTES+ROW_PAD bytes the row-byte count wraps to 0.
  - A word completes at most one pixel (2 bytes per word, 3 bytes per pixel).
  - Pixel output: pix_en=1 and pix_data are registered exactly 1 cycle after the rd_val_en cycle that supplied the R byte.
  - A pixel may complete on either the high or the low byte. Both byte positions and the phase carry across words and across row padding.
  - When the pixel counter reaches PIX_NUM: frame_done=1 in the same cycle as the final pix_en, busy=0, -> DONE. The remaining bytes of that word are discarded.
  - Gaps in rd_val_en: state holds, no outputs.
- State DONE:
  - All further rd_val_en words are ignored, with no pix_en (tail of the last sector).
  - start -> HEADER (new picture). Otherwise the state stays DONE.
- start while in HEADER or PIXEL: restarts the picture. Counters and phase are cleared, and the partial pixel is dropped. A rd_val_en in the same cycle as start is ignored.
- pix_en is never high for two consecutive cycles unless valid words arrive back-to-back. pix_data holds its value between strobes.

Test Plan:
1. HDR_BYTES=54, H_PIX=4, V_PIX=1. start, then 27 header words, then words 0x1020,0xF810,0x20F8 (pixels B=10,G=20,R=F8 twice) -> exactly 2 pix_en pulses, each 0xF902, each 1 cycle after its R-carrying word; no pix_en during the header.
2. H_PIX=3, V_PIX=2, 12 bytes per row (9 data + 3 pad). Pad bytes set to 0xFF; pixel bytes distinct -> 6 pixels; no 0xFF-derived pixel; the second row's first pixel assembles correctly across the odd pad boundary.
3. H_PIX=2, V_PIX=2, words with rd_val_en gaps of 0–5 random idle cycles -> same 4 pix_data values as the gapless run; frame_done on the 4th pix_en cycle; busy falls the next cycle.
4. After frame_done, feed 100 more valid words -> no pix_en, state DONE; then start and a fresh frame -> correct pixels again.
5. start asserted mid-PIXEL with phase=1 -> the partial pixel is discarded; the header is re-skipped; the first output equals the new stream's first pixel.
6. rst_n low for 1 cycle mid-frame -> all outputs 0 next cycle, no frame_done; following valid words are ignored until start.

Source files
------------

// File: rtl/bmp_rgb565_pack.sv
// BMP (24-bit, bottom-up rows) to RGB565 packer.
// Skips the file header, drops per-row padding, assembles B,G,R triplets
// from 16-bit read words and emits one RGB565 pixel per strobe.
module bmp_rgb565_pack #(
  parameter int unsigned H_PIX     = 1024,
  parameter int unsigned V_PIX     = 768,
  parameter int unsigned HDR_BYTES = 54
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rd_val_en,
  input  logic [15:0] rd_val_data,
  output logic        pix_en,
  output logic [15:0] pix_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned ROW_BYTES = H_PIX * 3;
  localparam int unsigned ROW_PAD   = (4 - (ROW_BYTES % 4)) % 4;
  localparam int unsigned ROW_TOT   = ROW_BYTES + ROW_PAD;
  localparam int unsigned PIX_NUM   = H_PIX * V_PIX;
  localparam int unsigned HDR_WORDS = HDR_BYTES / 2;
  localparam int unsigned HW        = $clog2(HDR_WORDS + 2);
  localparam int unsigned RW        = $clog2(ROW_TOT + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    PIXEL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [23:0]   pix_cnt_q, pix_cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    g_q, g_d;
  logic          pix_en_q, pix_en_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0]    byte_v;
  logic          fin;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hdr_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      phase_q      <= '0;
      b_q          <= '0;
      g_q          <= '0;
      pix_en_q     <= 1'b0;
      pix_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      phase_q      <= phase_d;
      b_q          <= b_d;
      g_q          <= g_d;
      pix_en_q     <= pix_en_d;
      pix_data_q   <= pix_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: header skip, per-byte pixel assembly and pad dropping.
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    row_cnt_d    = row_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    phase_d      = phase_q;
    b_d          = b_q;
    g_d          = g_q;
    pix_en_d     = 1'b0;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    // busy drops one cycle after the final pixel, as state has left PIXEL
    busy_d       = (state_q == HEADER) || (state_q == PIXEL);
    byte_v       = '0;
    fin          = 1'b0;

    if (start) begin
      state_d   = (HDR_WORDS == 0) ? PIXEL : HEADER;
      hdr_cnt_d = '0;
      row_cnt_d = '0;
      pix_cnt_d = '0;
      phase_d   = '0;
      b_d       = '0;
      g_d       = '0;
      busy_d    = 1'b1;
    end else if (rd_val_en) begin
      case (state_q)
        HEADER: begin
          hdr_cnt_d = hdr_cnt_q + HW'(1);
          if (hdr_cnt_q == HW'(HDR_WORDS - 1)) begin
            state_d = PIXEL;
          end
        end
        PIXEL: begin
          // Both bytes of the word are walked in file order; the _d copies
          // carry phase/row position from the high byte into the low byte.
          for (int unsigned i = 0; i < 2; i++) begin
            if (!fin) begin
              byte_v = (i == 0) ? rd_val_data[15:8] : rd_val_data[7:0];
              if (row_cnt_d < RW'(ROW_BYTES)) begin
                case (phase_d)
                  2'd0: begin
                    b_d     = byte_v;
                    phase_d = 2'd1;
                  end
                  2'd1: begin
                    g_d     = byte_v;
                    phase_d = 2'd2;
                  end
                  default: begin
                    pix_en_d   = 1'b1;
                    pix_data_d = {byte_v[7:3], g_d[7:2], b_d[7:3]};
                    phase_d    = 2'd0;
                    pix_cnt_d  = pix_cnt_d + 24'd1;
                    if (pix_cnt_d == 24'(PIX_NUM)) begin
                      fin          = 1'b1;
                      frame_done_d = 1'b1;
                      state_d      = DONE;
                    end
                  end
                endcase
              end
              row_cnt_d = (row_cnt_d == RW'(ROW_TOT - 1)) ? '0 : row_cnt_d + RW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pix_en     = pix_en_q;
  assign pix_data   = pix_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
